// File: rtl/stopwatch_ctrl.sv
// Stopwatch button sequencer: per-button sync/debounce lanes feeding a 4-state control FSM.
// Optional long-press forced reset on LAP/RESET is built when STOPWATCH_LONG_PRESS_EN is defined.

module stopwatch_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_MS - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // The tick sees sync[1] as registered before this edge, so a same-cycle sync change is not used yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (ms_tick) begin
        if (sync[1] != level) begin
          if (cnt == LAST) begin
            level <= ~level;
            cnt   <= '0;
            press <= ~level;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ms_tick,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_hold,
  output logic [1:0] state
);
  localparam int NUM_BTN = 2;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10, LAP = 2'b11} st_e;

  logic [NUM_BTN-1:0] btn_raw, db_lvl, press;
  st_e  st_q, st_nxt;
  logic clr_nxt, en_nxt, hold_nxt, long_fire;

  assign btn_raw = {btn_lap_reset, btn_start_stop};

  // Lane 0 is START/STOP, lane 1 is LAP/RESET.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    stopwatch_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clk     (clk),
      .rst     (rst),
      .ms_tick (ms_tick),
      .btn     (btn_raw[i]),
      .level   (db_lvl[i]),
      .press   (press[i])
    );
  end

`ifdef STOPWATCH_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_MS + 1);
  localparam logic [HW-1:0] LP_MAX = HW'(LONG_PRESS_MS);

  logic [HW-1:0] hold_cnt;

  // Saturating at LONG_PRESS_MS makes the forced reset fire once per hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      long_fire <= 1'b0;
    end else begin
      long_fire <= 1'b0;
      if (!db_lvl[1]) begin
        hold_cnt <= '0;
      end else if (ms_tick && hold_cnt != LP_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == LP_MAX - 1'b1) long_fire <= 1'b1;
      end
    end
  end
`else
  logic unused_lp;
  assign unused_lp = ^{32'(LONG_PRESS_MS), db_lvl};
  assign long_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      lap_hold  <= 1'b0;
    end else begin
      st_q      <= st_nxt;
      count_en  <= en_nxt;
      count_clr <= clr_nxt;
      lap_hold  <= hold_nxt;
    end
  end

  // START/STOP is tested first in every state, so it wins over a coincident LAP/RESET.
  always_comb begin
    st_nxt  = st_q;
    clr_nxt = 1'b0;
    if (long_fire) begin
      st_nxt  = IDLE;
      clr_nxt = 1'b1;
    end else begin
      case (st_q)
        IDLE: if (press[0]) st_nxt = RUN;
              else if (press[1]) clr_nxt = 1'b1;
        RUN:  if (press[0]) st_nxt = STOP;
              else if (press[1]) st_nxt = LAP;
        LAP:  if (press[0]) st_nxt = STOP;
              else if (press[1]) st_nxt = RUN;
        STOP: if (press[0]) st_nxt = RUN;
              else if (press[1]) begin
                st_nxt  = IDLE;
                clr_nxt = 1'b1;
              end
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    en_nxt   = (st_nxt == RUN) || (st_nxt == LAP);
    hold_nxt = (st_nxt == LAP);
  end

  assign state = st_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected FSM events are queued as buttons are driven
// and popped by a monitor whenever the state changes or count_clr pulses.
module tb_stopwatch_ctrl;
  localparam int DB = 2, LP = 5, TICK = 10;

  logic       clk = 1'b0, rst = 1'b1, ms_tick = 1'b0, btn_ss = 1'b0, btn_lr = 1'b0;
  logic       count_en, count_clr, lap_hold;
  logic [1:0] state;

  int         checks = 0, errors = 0, clr_exp = 0, clr_seen = 0;
  logic [2:0] sb[$];
  logic [1:0] prev_state = 2'b00;
  logic       prev_clr = 1'b0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_MS(DB), .LONG_PRESS_MS(LP)) dut (
    .clk            (clk),
    .rst            (rst),
    .ms_tick        (ms_tick),
    .btn_start_stop (btn_ss),
    .btn_lap_reset  (btn_lr),
    .count_en       (count_en),
    .count_clr      (count_clr),
    .lap_hold       (lap_hold),
    .state          (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic exp_evt(input logic [1:0] s, input logic c);
    sb.push_back({c, s});
    if (c) clr_exp++;
  endtask

  // One-cycle tick every TICK clocks, driven just after the edge.
  initial begin
    int tcnt = 0;
    forever begin
      @(posedge clk); #1;
      tcnt    = (tcnt == TICK - 1) ? 0 : tcnt + 1;
      ms_tick = (tcnt == TICK - 1);
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst) begin
      if (count_clr) begin
        clr_seen++;
        chk("clr_width", prev_clr, 0);
      end
      if (state != prev_state || count_clr) begin
        if (sb.size() == 0) chk("unexpected_evt", {count_clr, state}, 8);
        else begin
          e = sb.pop_front();
          chk("evt_state", state, e[1:0]);
          chk("evt_clr", count_clr, e[2]);
          chk("evt_en", count_en, (e[1:0] == 2'b01) || (e[1:0] == 2'b11));
          chk("evt_hold", lap_hold, e[1:0] == 2'b11);
        end
      end
    end
    prev_state = state;
    prev_clr   = count_clr;
  end

  // Leaves the bench 1 time unit after the edge that sampled a tick.
  task automatic align();
    int n = 0;
    @(negedge clk);
    while (!ms_tick && n < 4 * TICK) begin
      @(negedge clk);
      n++;
    end
    if (!ms_tick) chk("align_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  // which: 0 = ss, 1 = lr, 2 = both
  task automatic press(input int which, input int hold_ticks);
    align();
    if (which != 1) btn_ss = 1'b1;
    if (which != 0) btn_lr = 1'b1;
    repeat (hold_ticks * TICK) @(posedge clk);
    #1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (4 * TICK) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got %0d exp %0d", checks, 0);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_en", count_en, 0);
    chk("rst_clr", count_clr, 0);
    chk("rst_hold", lap_hold, 0);
    rst = 1'b0;

    // 1-clk glitches and a press that bounces off after one stable tick
    repeat (3) begin
      repeat ($urandom_range(3, 12)) @(posedge clk);
      #1 btn_ss = 1'b1;
      @(posedge clk);
      #1 btn_ss = 1'b0;
    end
    align();
    btn_ss = 1'b1;
    repeat (15) @(posedge clk);
    #1 btn_ss = 1'b0;
    repeat (4 * TICK) @(posedge clk);
    #1;
    chk("glitch_idle", state, 0);

    // clean press: 2 sync clk, sampled at ticks 1 and 2, press pulse, state update
    exp_evt(2'b01, 1'b0);
    align();
    btn_ss = 1'b1;
    n = 0;
    while (state != 2'b01 && n < 6 * TICK) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ss_latency", n, 2 * TICK + 1);
    repeat (TICK) @(posedge clk);
    #1 btn_ss = 1'b0;
    repeat (4 * TICK) @(posedge clk);
    #1;

    // RUN -> LAP -> RUN -> STOP -> IDLE
    exp_evt(2'b11, 1'b0); press(1, 2);
    exp_evt(2'b01, 1'b0); press(1, 2);
    exp_evt(2'b10, 1'b0); press(0, 2);
    exp_evt(2'b00, 1'b1); press(1, 2);
    chk("seq_clr_count", clr_seen, 1);

    // simultaneous presses from IDLE: ss wins
    exp_evt(2'b01, 1'b0); press(2, 2);
    exp_evt(2'b10, 1'b0); press(0, 2);
    exp_evt(2'b00, 1'b1); press(1, 2);

    // lr in IDLE clears without leaving IDLE
    exp_evt(2'b00, 1'b1); press(1, 2);

    // async reset in LAP with an ss debounce in flight; button held through release
    exp_evt(2'b01, 1'b0); press(0, 2);
    exp_evt(2'b11, 1'b0); press(1, 2);
    align();
    btn_ss = 1'b1;
    repeat (12) @(posedge clk);
    chk("pre_rst_state", state, 3);
    #3 rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_en", count_en, 0);
    chk("arst_hold", lap_hold, 0);
    chk("arst_clr", count_clr, 0);
    repeat (2) @(posedge clk);
    #1;
    exp_evt(2'b01, 1'b0);
    rst = 1'b0;
    repeat (5 * TICK) @(posedge clk);
    #1 btn_ss = 1'b0;
    repeat (4 * TICK) @(posedge clk);
    #1;
    chk("post_rst_state", state, 1);

`ifdef STOPWATCH_LONG_PRESS_EN
    // long hold from RUN: LAP at the press edge, then one forced clear to IDLE
    exp_evt(2'b11, 1'b0);
    exp_evt(2'b00, 1'b1);
    press(1, 8);
    chk("long_state", state, 0);
`endif

    repeat (2 * TICK) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("clr_count", clr_seen, clr_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
